mont_exp_ctrl: RTL and testbench

//  Left-to-right square-and-multiply sequencer for the Montgomery multiplier (MonMult-style core, 64-bit operands).

---
 rtl/mont_pkg.sv | 9 +
 rtl/mont_cond_sub.sv | 20 ++
 rtl/mont_exp_ctrl.sv | 140 ++++++++++++++
 tb/tb_mont_exp_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// mont_pkg: default widths, FSM states and operation codes shared by the Montgomery exponentiation controller
package mont_pkg;
    localparam int KW_DEF = 64;
    localparam int EW_DEF = 64;
    localparam int TO_CYC_DEF = 1023;
    localparam logic [KW_DEF-1:0] ONE_KW = KW_DEF'(1);
    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
    typedef enum logic [1:0] {SQR, MUL, CONV} op_t;
endpackage

// File: rtl/mont_cond_sub.sv
// mont_cond_sub: final conditional subtract of an unreduced product p < 2M, flagging results still >= M
module mont_cond_sub
    import mont_pkg::*;
#(
    parameter int KW = KW_DEF
) (
    input  logic [KW+1:0] p,
    input  logic [KW-1:0] m,
    output logic [KW-1:0] r,
    output logic          fault
);
    logic [KW+1:0] m_x;
    logic [KW+1:0] d;
    always_comb begin
        m_x = {2'b00, m};
        d = p >= m_x ? p - m_x : p;
        r = d[KW-1:0];
        fault = d >= m_x;
    end
endmodule

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: left-to-right square-and-multiply sequencer for a Montgomery multiplier; MONT_EXP_SKIP_LZ_EN skips leading-zero squarings (not constant time)
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int KW = KW_DEF,
    parameter int EW = EW_DEF,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic          pclk,
    input  logic          nreset,
    input  logic          start,
    input  logic [EW-1:0] exp_in,
    input  logic [KW-1:0] base_m,
    input  logic [KW-1:0] one_m,
    input  logic [KW-1:0] mod_in,
    output logic          busy,
    output logic          done,
    output logic [KW-1:0] result,
    output logic          err,
    output logic          mm_go,
    output logic [KW-1:0] mm_a,
    output logic [KW-1:0] mm_b,
    output logic [KW-1:0] mm_m,
    input  logic [KW+1:0] mm_p,
    input  logic          mm_ready
);
    localparam int IW = $clog2(EW);
    localparam int TW = $clog2(TO_CYC + 1);
`ifdef MONT_EXP_SKIP_LZ_EN
    localparam state_t ENTRY = GAP;
`else
    localparam state_t ENTRY = RUN;
`endif

    state_t        state, state_nx;
    op_t           op, op_nx;
    logic [KW-1:0] acc, acc_nx, base_r, b_nx, red_p;
    logic [EW-1:0] exp_r;
    logic [IW-1:0] idx, idx_nx;
    logic [TW-1:0] timer;
    logic          load, err_set, red_fault, skip;

    mont_cond_sub #(.KW(KW)) u_sub (
        .p     (mm_p),
        .m     (mm_m),
        .r     (red_p),
        .fault (red_fault)
    );

`ifdef MONT_EXP_SKIP_LZ_EN
    // lead: no exponent 1-bit consumed yet, so acc still holds one_m
    logic lead;
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) lead <= 1'b0;
        else lead <= load ? 1'b1 : (state == GAP && op_nx == MUL) ? 1'b0 : lead;
    end
    assign skip = lead;
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        load = state == IDLE && start;
        state_nx = state;
        op_nx = op;
        idx_nx = idx;
        acc_nx = acc;
        err_set = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nx = ENTRY;
                op_nx = SQR;
                idx_nx = IW'(EW - 1);
                acc_nx = one_m;
            end
            RUN: if (mm_ready) begin
                state_nx = GAP;
                acc_nx = red_p;
                err_set = red_fault;
            end else if (timer == TW'(TO_CYC)) begin
                state_nx = DONE;
                err_set = 1'b1;
            end
            GAP: if (op == CONV) begin
                state_nx = DONE;
            end else if (op == SQR && exp_r[idx]) begin
                state_nx = RUN;
                op_nx = MUL;
            end else begin
                state_nx = skip && idx != '0 ? GAP : RUN;
                op_nx = idx != '0 ? SQR : CONV;
                idx_nx = idx != '0 ? idx - IW'(1) : idx;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        b_nx = op_nx == SQR ? acc_nx : op_nx == MUL ? base_r : KW'(ONE_KW);
    end

    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            op <= SQR;
            acc <= '0;
            idx <= '0;
            timer <= '0;
            exp_r <= '0;
            base_r <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
            err <= 1'b0;
            mm_go <= 1'b0;
            mm_a <= '0;
            mm_b <= '0;
            mm_m <= '0;
        end else begin
            state <= state_nx;
            op <= op_nx;
            acc <= acc_nx;
            idx <= idx_nx;
            timer <= state == RUN ? timer + TW'(1) : '0;
            busy <= state_nx != IDLE;
            done <= state == DONE;
            mm_go <= state_nx == RUN;
            err <= load ? 1'b0 : err | err_set;
            if (load) begin
                exp_r <= exp_in;
                base_r <= base_m;
                mm_m <= mod_in;
            end
            if (state == DONE) result <= acc;
            // operands are captured once on RUN entry and held for the whole multiply
            if (state_nx == RUN && state != RUN) begin
                mm_a <= acc_nx;
                mm_b <= b_nx;
            end
        end
    end
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb_mont_exp_ctrl: scoreboard bench with a behavioural Montgomery multiplier and a plain modular-exponent reference
module tb_mont_exp_ctrl;
    localparam int KW = 64;
    localparam int EW = 64;
    localparam int TO_CYC = 1023;

    typedef struct {
        logic [KW-1:0] res;
        logic          err;
        int            nops;
        int            gocyc;
    } exp_t;

    logic          pclk, nreset, start, busy, done, err, mm_go, mm_ready;
    logic [EW-1:0] exp_in;
    logic [KW-1:0] base_m, one_m, mod_in, result, mm_a, mm_b, mm_m;
    logic [KW+1:0] mm_p;
    int            mmode;
    int            n_chk = 0;
    int            n_fail = 0;
    exp_t          sbq[$];

    mont_exp_ctrl #(.KW(KW), .EW(EW), .TO_CYC(TO_CYC)) dut (
        .pclk     (pclk),
        .nreset   (nreset),
        .start    (start),
        .exp_in   (exp_in),
        .base_m   (base_m),
        .one_m    (one_m),
        .mod_in   (mod_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .err      (err),
        .mm_go    (mm_go),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_m     (mm_m),
        .mm_p     (mm_p),
        .mm_ready (mm_ready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [KW-1:0] one_of(input logic [KW-1:0] m);
        logic [127:0] t;
        t = (128'd1 << 64) % {64'd0, m};
        return t[KW-1:0];
    endfunction

    function automatic logic [KW-1:0] to_m(input logic [KW-1:0] b, input logic [KW-1:0] m);
        logic [127:0] t;
        t = {b, 64'd0} % {64'd0, m};
        return t[KW-1:0];
    endfunction

    // right-to-left binary exponentiation on plain integers
    function automatic logic [KW-1:0] ref_exp(input logic [KW-1:0] b, input logic [EW-1:0] e, input logic [KW-1:0] m);
        logic [127:0] r, x, mm;
        mm = {64'd0, m};
        r = 128'd1 % mm;
        x = {64'd0, b} % mm;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[KW-1:0];
    endfunction

    // a*b*2^-64 mod m: reduce the product, then halve modulo m 64 times
    function automatic logic [KW+1:0] mont_model(input logic [KW-1:0] a, input logic [KW-1:0] b, input logic [KW-1:0] m);
        logic [129:0] x, mm;
        mm = {66'd0, m};
        x = ({66'd0, a} * {66'd0, b}) % mm;
        for (int i = 0; i < KW; i++) x = x[0] ? (x + mm) >> 1 : x >> 1;
        return x[KW+1:0];
    endfunction

    function automatic int nops_of(input logic [EW-1:0] e);
`ifdef MONT_EXP_SKIP_LZ_EN
        int msb;
        msb = -1;
        for (int i = 0; i < EW; i++) if (e[i]) msb = i;
        return e == '0 ? 1 : msb + $countones(e) + 1;
`else
        return EW + $countones(e) + 1;
`endif
    endfunction

    function automatic exp_t mk(input logic [KW-1:0] res, input logic e, input int nops, input int gocyc);
        exp_t x;
        x.res = res;
        x.err = e;
        x.nops = nops;
        x.gocyc = gocyc;
        return x;
    endfunction

    // behavioural multiplier: answers 10 cycles after GO, cleared whenever GO drops
    initial begin
        int cnt;
        logic [KW+1:0] p, m66;
        cnt = 0;
        mm_ready = 1'b0;
        mm_p = '0;
        forever begin
            @(negedge pclk);
            if (!mm_go) begin
                cnt = 0;
                mm_ready = 1'b0;
            end else if (!mm_ready) begin
                cnt++;
                if (cnt == 10 && mmode != 4) begin
                    m66 = {2'b00, mm_m};
                    p = mont_model(mm_a, mm_b, mm_m);
                    mm_p = mmode == 2 ? m66 + 66'd4 : mmode == 3 ? 2 * m66 + 66'd1 :
                           (mmode == 1 && $urandom_range(0, 1) == 1) ? p + m66 : p;
                    mm_ready = 1'b1;
                end
            end
        end
    end

    // monitor: op counting, GO gap / operand stability, and scoreboard pop on done
    initial begin
        logic pgo, pdone, pbusy, unst;
        logic [KW-1:0] a0, b0;
        int ops, gocyc, gap;
        exp_t x;
        pgo = 0; pdone = 0; pbusy = 0; unst = 0;
        a0 = '0; b0 = '0;
        ops = 0; gocyc = 0; gap = 0;
        forever begin
            @(posedge pclk);
            #1;
            if (busy && !pbusy) begin
                ops = 0;
                gocyc = 0;
                gap = 0;
            end
            if (mm_go) begin
                gocyc++;
                if (!pgo) begin
`ifndef MONT_EXP_SKIP_LZ_EN
                    if (ops > 0) chk("gap_len", gap, 1);
`endif
                    ops++;
                    a0 = mm_a;
                    b0 = mm_b;
                    unst = 0;
                end else if (mm_a !== a0 || mm_b !== b0) begin
                    unst = 1;
                end
            end else begin
                if (pgo) begin
                    chk("opnd_stable", unst, 0);
                    gap = 0;
                end
                if (busy) gap++;
            end
            if (pdone) chk("done_pulse", done, 0);
            if (done) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 result=%0h expected no done", result);
                end else begin
                    x = sbq.pop_front();
                    chk("result", result, x.res);
                    chk("err", err, x.err);
                    chk("busy_at_done", busy, 0);
                    if (x.nops >= 0) chk("op_count", ops, x.nops);
                    if (x.gocyc >= 0) chk("run_cycles", gocyc, x.gocyc);
                end
            end
            pgo = mm_go;
            pdone = done;
            pbusy = busy;
        end
    end

    task automatic issue(input logic [KW-1:0] m, input logic [KW-1:0] b, input logic [EW-1:0] e, input exp_t x);
        @(negedge pclk);
        mod_in = m;
        one_m = one_of(m);
        base_m = to_m(b, m);
        exp_in = e;
        start = 1'b1;
        sbq.push_back(x);
        @(negedge pclk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 20000) begin
            @(negedge pclk);
            n++;
        end
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no done after %0d cycles expected done", nm, n);
            sbq.delete();
        end
        repeat (3) @(negedge pclk);
    endtask

    task automatic std_run(input logic [KW-1:0] m, input logic [KW-1:0] b, input logic [EW-1:0] e, input string nm);
        issue(m, b, e, mk(ref_exp(b, e, m), 1'b0, nops_of(e), -1));
        wait_idle(nm);
    endtask

    initial begin
        logic [KW-1:0] m, b;
        logic [EW-1:0] e;
        int n;
        nreset = 1'b0;
        start = 1'b0;
        exp_in = '0;
        base_m = '0;
        one_m = '0;
        mod_in = '0;
        mmode = 0;
        repeat (3) @(negedge pclk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_go", mm_go, 0);
        chk("rst_result", result, 0);
        chk("rst_mm_m", mm_m, 0);
        nreset = 1'b1;
        @(negedge pclk);

        std_run(64'd13, 64'd5, 64'd0, "e0");
        std_run(64'd13, 64'd5, 64'd1, "e1");
        std_run(64'd13, 64'd5, 64'd2, "e2");

        mmode = 2;
        issue(64'd13, 64'd5, 64'd0, mk(64'd4, 1'b0, nops_of(64'd0), -1));
        wait_idle("p_m_plus_4");
        mmode = 3;
        issue(64'd13, 64'd5, 64'd0, mk(64'd14, 1'b1, -1, -1));
        wait_idle("p_2m_plus_1");

        mmode = 4;
        issue(64'd13, 64'd5, 64'd0, mk(64'd3, 1'b1, 1, TO_CYC + 1));
        wait_idle("watchdog");
        chk("go_after_abort", mm_go, 0);
        mmode = 0;

        m = {$urandom, $urandom} | 64'd1;
        b = {$urandom, $urandom} % m;
        e = {$urandom, $urandom};
        issue(m, b, e, mk(ref_exp(b, e, m), 1'b0, nops_of(e), -1));
        repeat (40) @(negedge pclk);
        mod_in = 64'd13;
        exp_in = 64'd2;
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        wait_idle("start_while_busy");
        repeat (20) @(negedge pclk);
        chk("busy_after_ignored", busy, 0);

        issue(m, b, e, mk('0, 1'b0, -1, -1));
        n = 0;
        while (!mm_go && n < 200) begin
            @(negedge pclk);
            n++;
        end
        repeat (3) @(posedge pclk);
        #2 nreset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_go", mm_go, 0);
        chk("arst_result", result, 0);
        chk("arst_mm_a", mm_a, 0);
        chk("arst_mm_b", mm_b, 0);
        chk("arst_mm_m", mm_m, 0);
        sbq.delete();
        repeat (2) @(negedge pclk);
        nreset = 1'b1;
        std_run(64'd13, 64'd5, 64'd2, "after_reset");

        for (int k = 0; k < 12; k++) begin
            m = {$urandom, $urandom} | 64'd1;
            if (m == 64'd1) m = 64'd3;
            b = {$urandom, $urandom} % m;
            e = k == 0 ? '1 : k == 1 ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
            mmode = $urandom_range(0, 1);
            std_run(m, b, e, "random");
        end
        mmode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got no end of test expected finish");
        $fatal(1, "global timeout");
    end
endmodule
